// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit with Hi/Lo registers.
// Fixed 33-cycle latency for MULT/MULTU/DIV/DIVU: one radix-2 step per cycle.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n;
  logic [W-1:0]  hi_n, lo_n;
  logic          is_div, is_div_n;
  logic          sgn_a, sgn_a_n, sgn_b, sgn_b_n;
  logic          b_zero, b_zero_n;
  logic [W-1:0]  a_raw, a_raw_n;
  logic [W-1:0]  opnd, opnd_n;
  logic [W-1:0]  acc_hi, acc_hi_n;
  logic [W-1:0]  acc_lo, acc_lo_n;

  // Operand capture: magnitudes for signed ops (op[0]==0 means signed)
  logic          in_sgn_a, in_sgn_b;
  logic [W-1:0]  a_mag, b_mag;
  assign in_sgn_a = ~op[0] & a[W-1];
  assign in_sgn_b = ~op[0] & b[W-1];
  assign a_mag    = in_sgn_a ? W'(-a) : a;
  assign b_mag    = in_sgn_b ? W'(-b) : b;

  // Shift-add step: add multiplicand on LSB of multiplier, shift {acc_hi,acc_lo} right
  logic [W:0]    mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {W{1'b0}})};

  // Restoring divide step: partial remainder shifted left with next dividend bit
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  div_diff;
  assign div_shift = {acc_hi, acc_lo[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = W'(div_shift - {1'b0, opnd});

  // Sign fix-up of the final magnitudes
  logic [2*W-1:0] prod, prod_res;
  logic [W-1:0]   quot_res, rem_res, a_orig;
  assign prod     = {acc_hi, acc_lo};
  assign prod_res = (sgn_a ^ sgn_b) ? (2*W)'(-prod) : prod;
  assign quot_res = (sgn_a ^ sgn_b) ? W'(-acc_lo) : acc_lo;
  assign rem_res  = sgn_a ? W'(-acc_hi) : acc_hi;
  assign a_orig   = a_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
      hi     <= hi_n;
      lo     <= lo_n;
      is_div <= is_div_n;
      sgn_a  <= sgn_a_n;
      sgn_b  <= sgn_b_n;
      b_zero <= b_zero_n;
      a_raw  <= a_raw_n;
      opnd   <= opnd_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    done_n   = 1'b0;
    hi_n     = hi;
    lo_n     = lo;
    is_div_n = is_div;
    sgn_a_n  = sgn_a;
    sgn_b_n  = sgn_b;
    b_zero_n = b_zero;
    a_raw_n  = a_raw;
    opnd_n   = opnd;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_RUN;
          busy_n   = 1'b1;
          cnt_n    = '0;
          is_div_n = op[1];
          sgn_a_n  = in_sgn_a;
          sgn_b_n  = in_sgn_b;
          b_zero_n = (b == '0);
          a_raw_n  = a;
          acc_hi_n = '0;
          opnd_n   = op[1] ? b_mag : a_mag;
          acc_lo_n = op[1] ? a_mag : b_mag;
        end else begin
          if (hi_we) hi_n = wdata;
          if (lo_we) lo_n = wdata;
        end
      end
      S_RUN: begin
        cnt_n = cnt + CW'(1);
        if (is_div) begin
          acc_hi_n = div_ge ? div_diff : div_shift[W-1:0];
          acc_lo_n = {acc_lo[W-2:0], div_ge};
        end else begin
          acc_hi_n = mul_sum[W:1];
          acc_lo_n = {mul_sum[0], acc_lo[W-1:1]};
        end
        if (cnt == CW'(31)) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        if (!is_div) begin
          hi_n = prod_res[2*W-1:W];
          lo_n = prod_res[W-1:0];
        end else if (b_zero) begin
          hi_n = a_orig;
          lo_n = {W{1'b1}};
        end else begin
          hi_n = rem_res;
          lo_n = quot_res;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
